// File: rtl/wb_regfile_pkg.sv
// Shared CPU package: register-index width, data width and the write-back
// move/byte-merge opcodes used by the pipeline buffers and the register file.
package wb_regfile_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;

  typedef logic [REG_IDX_W-1:0] regIdx_t;
  typedef logic [DATA_W-1:0]    word_t;

  typedef enum logic [3:0] {
    MOV_NONE = 4'h0,
    MOV_L    = 4'h1,
    MOV_H    = 4'h2,
    MOV_SWAP = 4'h3
  } movOp_e;

endpackage

// File: rtl/wb_merge.sv
// Write-back byte merge: combines the new source value with the old contents
// of the destination register according to the move opcode.
module wb_merge
  import wb_regfile_pkg::*;
(
  input  word_t      src,
  input  word_t      old,
  input  logic [3:0] movOP,
  output word_t      merged
);

  // Reserved encodings fall through to a plain full-word write.
  always_comb begin
    merged = src;
    case (movOP)
      MOV_L:    merged = {old[15:8], src[7:0]};
      MOV_H:    merged = {src[7:0], old[7:0]};
      MOV_SWAP: merged = {src[7:0], src[15:8]};
      default:  merged = src;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: byte-merged primary write, divide remainder
// write, write-through read bypass and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int REM_REG = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        Div_in,
  input  logic [3:0]  WriteReg_in,
  input  logic [15:0] ALU_Result,
  input  logic [15:0] ReadData,
  input  logic [15:0] Remainder_in,
  input  logic [3:0]  movOP_in,
  input  logic [3:0]  ReadReg1,
  input  logic [3:0]  ReadReg2,
  output logic [15:0] ReadData1,
  output logic [15:0] ReadData2,
  output logic [15:0] WriteBackData_out,
  output logic [15:0] RetireCount
);

  localparam int      NSLOTS  = 1 << REG_IDX_W;
  localparam regIdx_t REM_IDX = regIdx_t'(REM_REG);

  logic [NSLOTS-1:0][DATA_W-1:0] regs;
  logic [NSLOTS-1:0][DATA_W-1:0] wrVal;
  logic [NSLOTS-1:0]             wrEn;
  word_t                         src;
  word_t                         merged;

  assign src = MemToReg_in ? ReadData : ALU_Result;

  wb_merge uMerge (
    .src    (src),
    .old    (regs[WriteReg_in]),
    .movOP  (movOP_in),
    .merged (merged)
  );

  assign WriteBackData_out = merged;

  // Per-slot write decode; remainder assigned last so it wins on collision.
  // Gated by rst so the bypass shows reset contents while writes are dropped.
  always_comb begin
    wrEn  = '0;
    wrVal = '0;
    for (int i = 0; i < NSLOTS; i++) wrVal[i] = merged;
    if (!rst && RegWrite_in) begin
      wrEn[WriteReg_in] = 1'b1;
      if (Div_in) begin
        wrEn[REM_IDX]  = 1'b1;
        wrVal[REM_IDX] = Remainder_in;
      end
    end
    for (int i = 0; i < NSLOTS; i++)
      if (i == 0 || i >= NREGS) wrEn[i] = 1'b0;
  end

  for (genvar g = 0; g < NSLOTS; g++) begin : gReg
    if (g > 0 && g < NREGS) begin : gFlop
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          regs[g] <= '0;
        else if (wrEn[g]) regs[g] <= wrVal[g];
      end
    end else begin : gZero
      assign regs[g] = '0;
    end
  end

  assign ReadData1 = wrEn[ReadReg1] ? wrVal[ReadReg1] : regs[ReadReg1];
  assign ReadData2 = wrEn[ReadReg2] ? wrVal[ReadReg2] : regs[ReadReg2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      RetireCount <= '0;
    else if (RegWrite_in && (WriteReg_in != '0 || Div_in))
      RetireCount <= RetireCount + 16'd1;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a register-file model predicts bypass and
// post-edge contents; expected post-edge values are queued and drained.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemToReg_in, RegWrite_in, Div_in;
  logic [3:0]  WriteReg_in, movOP_in, ReadReg1, ReadReg2;
  logic [15:0] ALU_Result, ReadData, Remainder_in;
  logic [15:0] ReadData1, ReadData2, WriteBackData_out, RetireCount;

  always #5 clk = ~clk;

  wb_regfile #(.NREGS(16), .REM_REG(15)) dut (
    .clk(clk), .rst(rst),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .Div_in(Div_in),
    .WriteReg_in(WriteReg_in), .ALU_Result(ALU_Result), .ReadData(ReadData),
    .Remainder_in(Remainder_in), .movOP_in(movOP_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteBackData_out(WriteBackData_out), .RetireCount(RetireCount)
  );

  typedef struct {
    string       tag;
    bit          isCnt;
    logic [3:0]  addr;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl[16];
  logic [15:0] mdlCnt;
  int          errs   = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mrg(input logic [3:0] op, input logic [15:0] s,
                                      input logic [15:0] o);
    case (op)
      4'h1:    return {o[15:8], s[7:0]};
      4'h2:    return {s[7:0], o[7:0]};
      4'h3:    return {s[7:0], s[15:8]};
      default: return s;
    endcase
  endfunction

  task automatic mdlReset();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mdlCnt = '0;
  endtask

  // One write-back transaction: checks same-cycle forwarding/bypass, queues the
  // post-edge expectations, then drains the queue against the register reads.
  task automatic wb(input string tag, input bit mtr, input bit rw, input bit dv,
                    input logic [3:0] wr, input logic [15:0] alu, input logic [15:0] rd,
                    input logic [15:0] rem, input logic [3:0] op);
    logic [15:0] s, m, nCnt;
    logic [15:0] nxt[16];
    exp_t        e;
    @(negedge clk);
    MemToReg_in = mtr; RegWrite_in = rw; Div_in = dv; WriteReg_in = wr;
    ALU_Result = alu; ReadData = rd; Remainder_in = rem; movOP_in = op;
    ReadReg1 = wr; ReadReg2 = 4'd15;
    s    = mtr ? rd : alu;
    m    = mrg(op, s, mdl[wr]);
    nxt  = mdl;
    nCnt = mdlCnt;
    if (rw) begin
      if (wr != 0) nxt[wr] = m;
      if (dv)      nxt[15] = rem;
      if (wr != 0 || dv) nCnt = mdlCnt + 16'd1;
    end
    #1;
    chk({tag, ".wbd"}, WriteBackData_out, m);
    chk({tag, ".byp1"}, ReadData1, nxt[wr]);
    chk({tag, ".byp2"}, ReadData2, nxt[15]);
    sbq.push_back('{tag: {tag, ".reg"}, isCnt: 1'b0, addr: wr,    val: nxt[wr]});
    sbq.push_back('{tag: {tag, ".rem"}, isCnt: 1'b0, addr: 4'd15, val: nxt[15]});
    sbq.push_back('{tag: {tag, ".cnt"}, isCnt: 1'b1, addr: 4'd0,  val: nCnt});
    @(posedge clk);
    mdl    = nxt;
    mdlCnt = nCnt;
    #1;
    RegWrite_in = 1'b0; Div_in = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.isCnt) chk(e.tag, RetireCount, e.val);
      else begin
        ReadReg1 = e.addr;
        #1;
        chk(e.tag, ReadData1, e.val);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    MemToReg_in = 0; RegWrite_in = 1; Div_in = 0; WriteReg_in = 4'd4;
    ALU_Result = 16'hBEEF; ReadData = 0; Remainder_in = 0; movOP_in = 0;
    ReadReg1 = 4'd4; ReadReg2 = 4'd15;
    mdlReset();
    #3;
    chk("rst.rd1", ReadData1, 16'h0000);
    chk("rst.cnt", RetireCount, 16'h0000);
    chk("rst.wbd", WriteBackData_out, 16'hBEEF);
    @(posedge clk); #1;
    chk("rst.lost", ReadData1, 16'h0000);
    @(negedge clk);
    RegWrite_in = 0;
    rst = 1'b0;

    wb("r3",   0, 1, 0, 4'd3, 16'h1234, 16'h0000, 16'h0000, 4'h0);
    wb("r5",   0, 1, 0, 4'd5, 16'hAABB, 16'h0000, 16'h0000, 4'h0);
    wb("movl", 1, 1, 0, 4'd5, 16'hFFFF, 16'h00CC, 16'h0000, 4'h1);
    wb("movh", 0, 1, 0, 4'd5, 16'h0011, 16'h0000, 16'h0000, 4'h2);
    wb("swap", 0, 1, 0, 4'd5, 16'h1234, 16'h0000, 16'h0000, 4'h3);
    chk("swap.val", mdl[5], 16'h3412);
    wb("div2",  0, 1, 1, 4'd2,  16'h0007, 16'h0000, 16'h0003, 4'h0);
    wb("div15", 0, 1, 1, 4'd15, 16'h0009, 16'h0000, 16'h0003, 4'h0);
    wb("r0",    0, 1, 0, 4'd0,  16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    wb("nowr",  1, 0, 1, 4'd3,  16'h5555, 16'h6666, 16'h7777, 4'h1);
    wb("rsvd",  0, 1, 0, 4'd7,  16'hC3A5, 16'h0000, 16'h0000, 4'h9);

    for (int k = 0; k < 20; k++)
      wb("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
         16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 5)));

    // Bring the retire counter to 0xFFFF with back-to-back writes to R1.
    n = 16'hFFFF - mdlCnt;
    @(negedge clk);
    MemToReg_in = 0; RegWrite_in = 1; Div_in = 0; WriteReg_in = 4'd1;
    ALU_Result = 16'h0101; movOP_in = 0;
    repeat (n) @(posedge clk);
    mdl[1] = 16'h0101;
    mdlCnt = 16'hFFFF;
    @(negedge clk);
    RegWrite_in = 0;
    #1;
    chk("pre.cnt", RetireCount, 16'hFFFF);
    wb("wrap", 0, 1, 0, 4'd6, 16'h0606, 16'h0000, 16'h0000, 4'h0);
    chk("wrap.mdl", mdlCnt, 16'h0000);

    // Mid-cycle reset clears contents and counter before the next edge.
    @(negedge clk);
    ReadReg1 = 4'd5; ReadReg2 = 4'd15;
    #1;
    chk("mid.pre", ReadData1, mdl[5]);
    #1;
    rst = 1'b1;
    RegWrite_in = 1; WriteReg_in = 4'd5; ALU_Result = 16'h9999; movOP_in = 4'h1;
    #1;
    chk("mid.rd1", ReadData1, 16'h0000);
    chk("mid.rd2", ReadData2, 16'h0000);
    chk("mid.cnt", RetireCount, 16'h0000);
    chk("mid.wbd", WriteBackData_out, 16'h0099);
    @(posedge clk);
    @(negedge clk);
    RegWrite_in = 0;
    rst = 1'b0;
    mdlReset();
    wb("post", 0, 1, 0, 4'd6, 16'h4242, 16'h0000, 16'h0000, 4'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 16: number of 16-bit general registers (R0..R15).
REQ-002 SHALL have parameter REM_REG, default 15: register that receives the divide remainder.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports, in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- MemToReg_in  in  1  1 = write-back source is ReadData, 0 = ALU_Result.
- RegWrite_in  in  1  write-back enable.
- Div_in  in  1  instruction is a divide; the remainder is also written.
- WriteReg_in  in  4  destination register index.
- ALU_Result  in  16  ALU value from the MEM/WB stage.
- ReadData  in  16  memory value from the MEM/WB stage.
- Remainder_in  in  16  divide remainder.
- movOP_in  in  4  move/byte-merge opcode.
- ReadReg1, ReadReg2  in  4 each  decode-stage read addresses.
- ReadData1, ReadData2  out  16 each  decode-stage read data.
- WriteBackData_out  out  16  merged write-back value, for forwarding.
- RetireCount  out  16  count of committed register writes.

Function
REQ-005 Source value SHALL be src = MemToReg_in ? ReadData : ALU_Result.
REQ-006 Merged value SHALL be formed from src and old = current contents of WriteReg_in:
- movOP 0x0: src.
- 0x1 (MOVL): {old[15:8], src[7:0]}.
- 0x2 (MOVH): {src[7:0], old[7:0]}.
- 0x3 (SWAP): {src[7:0], src[15:8]}.
- 0x4..0xF: reserved; treated as 0x0.
REQ-007 WriteBackData_out SHALL be the combinational merged value every cycle, regardless of RegWrite_in.
REQ-008 On a rising clk edge with RegWrite_in=1 and WriteReg_in!=0, WriteReg_in SHALL take the merged value.
REQ-009 On a rising clk edge with RegWrite_in=1 and Div_in=1, REM_REG SHALL take Remainder_in in the same edge.
REQ-010 If WriteReg_in==REM_REG while Div_in=1, the remainder write SHALL win.
REQ-011 R0 SHALL always read 0x0000; writes to R0 SHALL be discarded.
REQ-012 Reads SHALL be combinational.
REQ-013 A read whose address equals a register being written this cycle (primary or remainder) SHALL return the value being written (write-through bypass), with REQ-010 priority applied; R0 excepted.
REQ-014 RegWrite_in=0 SHALL suppress all writes; Div_in and movOP_in are then ignored.
REQ-015 RetireCount SHALL increment by 1 on each edge where RegWrite_in=1 and at least one register actually changes target (WriteReg_in!=0 or Div_in=1).
REQ-016 RetireCount SHALL wrap from 0xFFFF to 0x0000.
REQ-017 Write latency SHALL be one edge; the value is visible on read ports the same cycle via bypass and from registers on the next cycle.

Reset
REQ-018 While rst=1, all registers and RetireCount SHALL be 0x0000 immediately (asynchronously).
REQ-019 Writes presented during reset SHALL be lost.
REQ-020 The first write SHALL occur on the first rising edge after rst deasserts.
REQ-021 Outputs during reset SHALL follow REQ-007 and REQ-012 on the reset contents.

Structure
REQ-022 movOP encodings (MOV_NONE, MOV_L, MOV_H, MOV_SWAP) and the register-index width SHALL live in the shared CPU package used by the pipeline buffers.
REQ-023 The byte-merge logic SHALL be one sub-module, wb_merge: combinational, inputs src/old/movOP, output merged.

Verification
REQ-024 Write R3 with ALU_Result=0x1234, MemToReg=0, movOP=0 -> same cycle ReadData1(R3)=0x1234 via bypass; next cycle 0x1234 from the register; RetireCount=1.
REQ-025 R5=0xAABB, then MOVL with ReadData=0x00CC, MemToReg=1 -> R5=0xAACC; then MOVH with src=0x0011 -> R5=0x11CC; then SWAP with src=0x1234 -> R5=0x3412.
REQ-026 Div_in=1, WriteReg=2, ALU_Result=0x0007, Remainder_in=0x0003 -> R2=0x0007 and R15=0x0003 after one edge; repeat with WriteReg=15 -> R15=0x0003.
REQ-027 RegWrite=1, WriteReg=0, value 0xFFFF -> R0 reads 0x0000 and RetireCount is unchanged; RegWrite=0 with any inputs -> no register changes.
REQ-028 Preload RetireCount to 0xFFFF by 65535 writes, one more write -> 0x0000; assert rst mid-cycle -> all reads and RetireCount are 0 before the next edge.
